// File: rtl/vending_pkg.sv
// Shared types, coin codes and pricing helpers
// for the vending credit controller.
package vending_pkg;

  localparam int MONEY_W = 4;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE,
    COMMIT
  } state_t;

  function automatic logic [MONEY_W-1:0] coin_value(
    input logic [1:0] code
  );
    logic [MONEY_W-1:0] v;
    unique case (code)
      COIN_1:  v = MONEY_W'(1);
      COIN_2:  v = MONEY_W'(2);
      COIN_5:  v = MONEY_W'(5);
      default: v = '0;
    endcase
    return v;
  endfunction

  // prices packed as {p3, p2, p1, p0}
  function automatic logic [MONEY_W-1:0] price_of(
    input logic [1:0]           id,
    input logic [4*MONEY_W-1:0] prices
  );
    return prices[id*MONEY_W +: MONEY_W];
  endfunction

endpackage

// File: rtl/change_picker.sv
// Picks the largest change coin that fits
// in the remaining credit.
module change_picker
  import vending_pkg::*;
(
  input  logic [MONEY_W-1:0] credit,
  output logic [1:0]         code,
  output logic [MONEY_W-1:0] value
);

  always_comb begin
    code  = COIN_NONE;
    value = '0;
    if (credit >= MONEY_W'(5)) begin
      code  = COIN_5;
      value = MONEY_W'(5);
    end else if (credit >= MONEY_W'(2)) begin
      code  = COIN_2;
      value = MONEY_W'(2);
    end else if (credit != '0) begin
      code  = COIN_1;
      value = MONEY_W'(1);
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending transaction controller: coins, credit,
// selection, change and machine money commit.
module vend_credit_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE0       = 3,
  parameter int PRICE1       = 4,
  parameter int PRICE2       = 6,
  parameter int PRICE3       = 9,
  parameter int INIT_MACHINE = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic               sel_valid,
  input  logic [1:0]         sel_id,
  input  logic               cancel,
  output logic               coin_reject,
  output logic               sel_denied,
  output logic               vend_valid,
  output logic [1:0]         vend_id,
  output logic               change_valid,
  output logic [1:0]         change_coin,
  output logic               busy,
  output logic               money_mode,
  output logic [MONEY_W-1:0] money_value
);

  localparam logic [4*MONEY_W-1:0] PRICES = {
    MONEY_W'(PRICE3), MONEY_W'(PRICE2),
    MONEY_W'(PRICE1), MONEY_W'(PRICE0)
  };

  state_t             state, st_n;
  logic [MONEY_W-1:0] credit, cr_n;
  logic [MONEY_W-1:0] machine, mc_n;
  logic [1:0]         sel_q;
  logic               rej, den, vnd, chg;
  logic [MONEY_W-1:0] cv, pr, lpr;
  logic [MONEY_W:0]   csum, msum;
  logic               coin_ok, can_buy;
  logic [1:0]         pick_code;
  logic [MONEY_W-1:0] pick_val;

  change_picker u_pick (
    .credit (credit),
    .code   (pick_code),
    .value  (pick_val)
  );

  // one extra bit catches credit/machine overflow
  assign cv      = coin_value(coin_code);
  assign csum    = {1'b0, credit} + {1'b0, cv};
  assign coin_ok = (coin_code != COIN_NONE) && !csum[MONEY_W];
  assign pr      = price_of(sel_id, PRICES);
  assign lpr     = price_of(sel_q, PRICES);
  assign msum    = {1'b0, machine} + {1'b0, pr};
  assign can_buy = (credit >= pr) && !msum[MONEY_W];

  always_comb begin
    st_n = state;
    cr_n = credit;
    mc_n = machine;
    rej  = 1'b0;
    den  = 1'b0;
    vnd  = 1'b0;
    chg  = 1'b0;
    unique case (state)
      IDLE: begin
        if (coin_valid) begin
          if (coin_ok) begin
            cr_n = csum[MONEY_W-1:0];
            st_n = COLLECT;
          end else begin
            rej = 1'b1;
          end
        end
        den = sel_valid;
      end
      COLLECT: begin
        if (cancel) begin
          rej  = coin_valid;
          st_n = (credit == '0) ? COMMIT : CHANGE;
        end else if (sel_valid) begin
          rej = coin_valid;
          if (can_buy) st_n = VEND;
          else den = 1'b1;
        end else if (coin_valid) begin
          if (coin_ok) cr_n = csum[MONEY_W-1:0];
          else rej = 1'b1;
        end
      end
      VEND: begin
        rej  = coin_valid;
        vnd  = 1'b1;
        cr_n = credit - lpr;
        mc_n = machine + lpr;
        st_n = (cr_n != '0) ? CHANGE : COMMIT;
      end
      CHANGE: begin
        rej  = coin_valid;
        chg  = 1'b1;
        cr_n = credit - pick_val;
        st_n = (cr_n == '0) ? COMMIT : CHANGE;
      end
      COMMIT: begin
        rej  = coin_valid;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      machine      <= MONEY_W'(INIT_MACHINE);
      sel_q        <= '0;
      coin_reject  <= 1'b0;
      sel_denied   <= 1'b0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_coin  <= '0;
      busy         <= 1'b0;
      money_mode   <= 1'b1;
      money_value  <= '0;
    end else begin
      state        <= st_n;
      credit       <= cr_n;
      machine      <= mc_n;
      coin_reject  <= rej;
      sel_denied   <= den;
      vend_valid   <= vnd;
      change_valid <= chg;
      busy         <= (state == VEND) ||
                      (state == CHANGE) ||
                      (state == COMMIT);
      money_mode   <= (state != COMMIT);
      money_value  <= (state == COMMIT) ? machine : cr_n;
      if (state == COLLECT && st_n == VEND)
        sel_q <= sel_id;
      if (vnd)
        vend_id <= sel_q;
      if (chg)
        change_coin <= pick_code;
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: a
// behavioural model queues expected outputs.
module tb_vend_credit_ctrl;

  typedef struct packed {
    logic       cv;
    logic [1:0] cc;
    logic       sv;
    logic [1:0] sid;
    logic       cn;
    logic       r;
  } stim_t;

  typedef struct packed {
    logic       coin_reject;
    logic       sel_denied;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       busy;
    logic       money_mode;
    logic [3:0] money_value;
  } out_t;

  localparam int PRICE [4] = '{3, 4, 6, 9};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic       cancel = 1'b0;
  logic       coin_reject, sel_denied, vend_valid;
  logic [1:0] vend_id, change_coin;
  logic       change_valid, busy, money_mode;
  logic [3:0] money_value;

  int nvec = 0;
  int nmis = 0;

  out_t exp_q[$];
  int   m_st, m_cr, m_mc;
  logic [1:0] m_sel, m_vid, m_cc;

  vend_credit_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .coin_reject  (coin_reject),
    .sel_denied   (sel_denied),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .busy         (busy),
    .money_mode   (money_mode),
    .money_value  (money_value)
  );

  always #5 clock = ~clock;

  function automatic stim_t st(
    input logic cv, input logic [1:0] cc,
    input logic sv, input logic [1:0] sid,
    input logic cn, input logic r
  );
    return '{cv, cc, sv, sid, cn, r};
  endfunction

  function automatic stim_t coin(input logic [1:0] c);
    return st(1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t sel(input logic [1:0] s);
    return st(1'b0, 2'd0, 1'b1, s, 1'b0, 1'b0);
  endfunction

  function automatic stim_t idle();
    return st(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t rst();
    return st(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
  endfunction

  function automatic stim_t cncl();
    return st(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
  endfunction

  function automatic out_t outs();
    return '{coin_reject, sel_denied, vend_valid,
             vend_id, change_valid, change_coin,
             busy, money_mode, money_value};
  endfunction

  function automatic int val_of(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model(input stim_t s);
    out_t o;
    int cvv, pr, nst;
    o = '0;
    o.money_mode = 1'b1;
    if (s.r) begin
      m_st = 0; m_cr = 0; m_mc = 0;
      m_sel = 2'd0; m_vid = 2'd0; m_cc = 2'd0;
      exp_q.push_back(o);
      return;
    end
    cvv = val_of(s.cc);
    o.busy = (m_st >= 2);
    nst = m_st;
    case (m_st)
      0: begin
        if (s.cv) begin
          if (cvv == 0) o.coin_reject = 1'b1;
          else begin m_cr += cvv; nst = 1; end
        end
        o.sel_denied = s.sv;
      end
      1: begin
        if (s.cn) begin
          o.coin_reject = s.cv;
          nst = (m_cr == 0) ? 4 : 3;
        end else if (s.sv) begin
          o.coin_reject = s.cv;
          pr = PRICE[s.sid];
          if (m_cr >= pr && m_mc + pr <= 15) begin
            nst = 2;
            m_sel = s.sid;
          end else o.sel_denied = 1'b1;
        end else if (s.cv) begin
          if (cvv == 0 || m_cr + cvv > 15) o.coin_reject = 1'b1;
          else m_cr += cvv;
        end
      end
      2: begin
        o.coin_reject = s.cv;
        pr = PRICE[m_sel];
        m_cr -= pr;
        m_mc += pr;
        m_vid = m_sel;
        o.vend_valid = 1'b1;
        nst = (m_cr > 0) ? 3 : 4;
      end
      3: begin
        o.coin_reject = s.cv;
        o.change_valid = 1'b1;
        if (m_cr >= 5) begin m_cc = 2'b11; m_cr -= 5; end
        else if (m_cr >= 2) begin m_cc = 2'b10; m_cr -= 2; end
        else begin m_cc = 2'b01; m_cr -= 1; end
        nst = (m_cr == 0) ? 4 : 3;
      end
      default: begin
        o.coin_reject = s.cv;
        nst = 0;
      end
    endcase
    o.vend_id = m_vid;
    o.change_coin = m_cc;
    if (m_st == 4) begin
      o.money_mode = 1'b0;
      o.money_value = 4'(m_mc);
    end else begin
      o.money_value = 4'(m_cr);
    end
    m_st = nst;
    exp_q.push_back(o);
  endtask

  task automatic apply(input stim_t s);
    reset      = s.r;
    coin_valid = s.cv;
    coin_code  = s.cc;
    sel_valid  = s.sv;
    sel_id     = s.sid;
    cancel     = s.cn;
    model(s);
  endtask

  task automatic test_reset();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(rst());
    v.push_back(idle());
    v.push_back(coin(2'b00));
    v.push_back(sel(2'd1));
    v.push_back(cncl());
    v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_reset[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_exact_sale();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b10));
    v.push_back(coin(2'b10));
    v.push_back(sel(2'd3));
    repeat (5) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_exact_sale[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_change();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b11));
    v.push_back(sel(2'd0));
    repeat (6) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_change[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_denied_cancel();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b10));
    v.push_back(sel(2'd1));
    v.push_back(idle());
    v.push_back(st(1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 1'b0));
    repeat (5) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_denied_cancel[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_credit_limit();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b10));
    v.push_back(coin(2'b10));
    v.push_back(coin(2'b01));
    v.push_back(coin(2'b01));
    v.push_back(coin(2'b00));
    v.push_back(cncl());
    v.push_back(coin(2'b01));
    repeat (8) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_credit_limit[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_machine_overflow();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b11));
    v.push_back(sel(2'd1));
    repeat (5) v.push_back(idle());
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b01));
    v.push_back(sel(2'd2));
    repeat (4) v.push_back(idle());
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b01));
    v.push_back(sel(2'd2));
    v.push_back(st(1'b1, 2'b01, 1'b1, 2'd0, 1'b0, 1'b0));
    repeat (7) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_machine_overflow[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b10));
    v.push_back(coin(2'b01));
    v.push_back(sel(2'd0));
    v.push_back(idle());
    v.push_back(idle());
    v.push_back(rst());
    v.push_back(idle());
    v.push_back(coin(2'b11));
    v.push_back(sel(2'd0));
    repeat (6) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_reset_mid[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    out_t e, got;
    v.push_back(rst());
    v.push_back(coin(2'b01));
    v.push_back(coin(2'b10));
    v.push_back(sel(2'd0));
    v.push_back(coin(2'b11));
    v.push_back(st(1'b1, 2'b10, 1'b1, 2'd1, 1'b1, 1'b0));
    v.push_back(coin(2'b11));
    v.push_back(coin(2'b10));
    v.push_back(sel(2'd3));
    v.push_back(coin(2'b10));
    v.push_back(sel(2'd3));
    repeat (6) v.push_back(idle());
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      got = outs();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL test_back_to_back[%0d] got %h expected %h", i, got, e);
      end
    end
  endtask

  initial begin
    m_st = 0; m_cr = 0; m_mc = 0;
    m_sel = 2'd0; m_vid = 2'd0; m_cc = 2'd0;
    #2;
    test_reset();
    test_exact_sale();
    test_change();
    test_denied_cancel();
    test_credit_limit();
    test_machine_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
